// File: rtl/os_result_drain_if.sv
// rtl/os_result_drain_if.sv - row output stream of the result drain
interface os_result_drain_if #(
   parameter int A_H       = 16,
   parameter int B_W       = 16,
   parameter int ACC_WIDTH = 32
);
   localparam int RW = (A_H > 1) ? $clog2(A_H) : 1;

   logic                     out_valid;
   logic                     out_ready;
   logic [B_W*ACC_WIDTH-1:0] out_data;
   logic [RW-1:0]            out_row;
   logic                     out_last;

   modport master (output out_valid, out_data, out_row, out_last, input out_ready);
   modport slave  (input out_valid, out_data, out_row, out_last, output out_ready);
endinterface

// File: rtl/os_result_drain.sv
// rtl/os_result_drain.sv - drains a finished output-stationary tile row by row, then pulses clc
module os_result_drain #(
   parameter int A_H       = 16,
   parameter int B_W       = 16,
   parameter int ACC_WIDTH = 32
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic                             tile_done,
   input  logic [2*ACC_WIDTH*A_H*B_W-1:0]   result,
   os_result_drain_if.master                dout,
   output logic                             clc,
   output logic                             busy,
   output logic                             err_ovr
);
   localparam int RW = (A_H > 1) ? $clog2(A_H) : 1;
   localparam logic [RW-1:0] LAST_ROW = RW'(A_H - 1);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_SEND  = 2'd1;
   localparam logic [1:0] S_CLEAR = 2'd2;

   logic [1:0]               state;
   logic [RW-1:0]            next_row;
   logic [RW-1:0]            load_row;
   logic [B_W*ACC_WIDTH-1:0] row_sum;
   logic                     at_last;

   assign at_last  = (dout.out_row == LAST_ROW);
   assign next_row = dout.out_row + 1'b1;
   // Clamp so the last row never indexes past the end of the result bus.
   assign load_row = (state == S_SEND && !at_last) ? next_row : '0;
   assign busy     = (state != S_IDLE);

   // Lane c of the row being loaded: lo + hi of PE (load_row, c), wrapping.
   always_comb begin
      row_sum = '0;
      for (int c = 0; c < B_W; c++) begin
         row_sum[c*ACC_WIDTH +: ACC_WIDTH] =
            result[(2*(c + int'(load_row)*B_W))*ACC_WIDTH +: ACC_WIDTH] +
            result[(2*(c + int'(load_row)*B_W) + 1)*ACC_WIDTH +: ACC_WIDTH];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state          <= S_IDLE;
         dout.out_valid <= 1'b0;
         dout.out_data  <= '0;
         dout.out_row   <= '0;
         dout.out_last  <= 1'b0;
         clc            <= 1'b0;
         err_ovr        <= 1'b0;
      end else begin
         if (tile_done && state != S_IDLE)
            err_ovr <= 1'b1;
         case (state)
            S_IDLE: begin
               if (tile_done) begin
                  dout.out_data  <= row_sum;
                  dout.out_row   <= '0;
                  dout.out_last  <= (A_H == 1);
                  dout.out_valid <= 1'b1;
                  state          <= S_SEND;
               end
            end
            S_SEND: begin
               if (dout.out_ready) begin
                  if (at_last) begin
                     dout.out_valid <= 1'b0;
                     clc            <= 1'b1;
                     state          <= S_CLEAR;
                  end else begin
                     dout.out_data <= row_sum;
                     dout.out_row  <= next_row;
                     dout.out_last <= (next_row == LAST_ROW);
                  end
               end
            end
            S_CLEAR: begin
               clc   <= 1'b0;
               state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_os_result_drain.sv
// tb/tb_os_result_drain.sv - randomized model-checked bench for os_result_drain
module tb_os_result_drain;
   localparam int AH = 4;
   localparam int BW = 4;
   localparam int AW = 32;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic tile_done = 1'b0;
   logic [2*AW*AH*BW-1:0] result;
   logic clc, busy, err_ovr;
   logic [31:0] lo [AH][BW];
   logic [31:0] hi [AH][BW];

   logic td1 = 1'b0;
   logic [2*AW*2-1:0] res1;
   logic clc1, busy1, err1;

   int total = 0;
   int bad = 0;
   bit chk_en = 1'b0;

   bit   m_busy, m_valid, m_clc, m_err;
   int   m_row;
   logic [BW*AW-1:0] m_data;

   os_result_drain_if #(.A_H(AH), .B_W(BW), .ACC_WIDTH(AW)) dif ();
   os_result_drain_if #(.A_H(1), .B_W(2), .ACC_WIDTH(AW)) dif1 ();

   os_result_drain #(.A_H(AH), .B_W(BW), .ACC_WIDTH(AW)) u_dut (
      .clk(clk), .rst(rst), .tile_done(tile_done), .result(result),
      .dout(dif), .clc(clc), .busy(busy), .err_ovr(err_ovr));

   os_result_drain #(.A_H(1), .B_W(2), .ACC_WIDTH(AW)) u_dut1 (
      .clk(clk), .rst(rst), .tile_done(td1), .result(res1),
      .dout(dif1), .clc(clc1), .busy(busy1), .err_ovr(err1));

   always #5 clk = ~clk;

   always_comb begin
      result = '0;
      for (int r = 0; r < AH; r++)
         for (int c = 0; c < BW; c++) begin
            result[(2*(c + r*BW))*AW +: AW]     = lo[r][c];
            result[(2*(c + r*BW) + 1)*AW +: AW] = hi[r][c];
         end
   end

   function automatic logic [BW*AW-1:0] exp_row(int r);
      logic [BW*AW-1:0] v;
      logic [31:0] s;
      for (int c = 0; c < BW; c++) begin
         s = lo[r][c] + hi[r][c];
         v[c*AW +: AW] = s;
      end
      return v;
   endfunction

   task automatic chk(string name, logic [127:0] act, logic [127:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic step(int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic wait_idle();
      int n = 0;
      while (busy && n < 100) begin
         step(1);
         n++;
      end
      chk("idle_timeout", busy, 0);
   endtask

   // Transaction-level reference: a tile is a sequence of AH rows, then one clear cycle.
   always @(posedge clk) begin
      if (rst) begin
         m_busy = 0; m_valid = 0; m_clc = 0; m_err = 0; m_row = 0; m_data = '0;
      end else begin
         if (tile_done && m_busy) m_err = 1;
         if (!m_busy) begin
            if (tile_done) begin
               m_busy = 1; m_valid = 1; m_row = 0; m_data = exp_row(0);
            end
         end else if (m_clc) begin
            m_clc = 0; m_busy = 0;
         end else if (m_valid && dif.out_ready) begin
            if (m_row == AH - 1) begin
               m_valid = 0; m_clc = 1;
            end else begin
               m_row++;
               m_data = exp_row(m_row);
            end
         end
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         chk("valid", dif.out_valid, m_valid);
         chk("clc", clc, m_clc);
         chk("busy", busy, m_busy);
         chk("err_ovr", err_ovr, m_err);
         if (m_valid) begin
            chk("data", dif.out_data, m_data);
            chk("row", dif.out_row, m_row);
            chk("last", dif.out_last, m_row == AH - 1);
         end
      end
   end

   initial begin
      int n;
      dif.out_ready = 1'b0;
      dif1.out_ready = 1'b0;
      res1 = '0;
      for (int r = 0; r < AH; r++)
         for (int c = 0; c < BW; c++) begin
            lo[r][c] = '0; hi[r][c] = '0;
         end
      step(3);
      rst = 1'b0;
      chk_en = 1'b1;
      step(1);
      chk("rst_valid", dif.out_valid, 0);
      chk("rst_data", dif.out_data, 0);
      chk("rst_row", dif.out_row, 0);
      chk("rst_last", dif.out_last, 0);
      chk("rst_busy", busy, 0);
      chk("rst_clc", clc, 0);
      chk("rst_err", err_ovr, 0);

      // T1: lane = r*16 + c + 1, one row per cycle
      for (int r = 0; r < AH; r++)
         for (int c = 0; c < BW; c++) begin
            lo[r][c] = 32'(r*16 + c); hi[r][c] = 32'd1;
         end
      dif.out_ready = 1'b1;
      tile_done = 1'b1;
      step(1);
      tile_done = 1'b0;
      chk("t1_r0_valid", dif.out_valid, 1);
      chk("t1_r0_lane2", dif.out_data[2*AW +: AW], 32'd3);
      step(1);
      chk("t1_r1_lane0", dif.out_data[0 +: AW], 32'd17);
      step(1);
      chk("t1_r2_lane3", dif.out_data[3*AW +: AW], 32'd36);
      step(1);
      chk("t1_r3_last", dif.out_last, 1);
      chk("t1_r3_lane1", dif.out_data[1*AW +: AW], 32'd50);
      step(1);
      chk("t1_clc", clc, 1);
      chk("t1_valid_low", dif.out_valid, 0);
      step(1);
      chk("t1_clc_end", clc, 0);
      chk("t1_busy_end", busy, 0);

      // Minimum turnaround, tile_done to clc inclusive
      tile_done = 1'b1;
      step(1);
      tile_done = 1'b0;
      n = 1;
      while (!clc && n < 50) begin
         step(1);
         n++;
      end
      chk("turnaround", n + 1, AH + 2);
      wait_idle();

      // T2: backpressure 0,0,1 per row
      dif.out_ready = 1'b0;
      tile_done = 1'b1;
      step(1);
      tile_done = 1'b0;
      for (int r = 0; r < AH; r++) begin
         dif.out_ready = 1'b0;
         step(2);
         dif.out_ready = 1'b1;
         step(1);
      end
      chk("t2_clc", clc, 1);
      wait_idle();

      // T3: wrap-around lane arithmetic
      lo[0][0] = 32'hFFFF_FFFF; hi[0][0] = 32'd2;
      lo[0][1] = 32'hFFFF_FFFB; hi[0][1] = 32'd3;
      tile_done = 1'b1;
      step(1);
      tile_done = 1'b0;
      chk("t3_wrap", dif.out_data[0 +: AW], 32'h0000_0001);
      chk("t3_neg", dif.out_data[AW +: AW], 32'hFFFF_FFFE);
      wait_idle();

      // T4: overrun while showing row 1
      tile_done = 1'b1;
      step(1);
      tile_done = 1'b0;
      step(1);
      tile_done = 1'b1;
      step(1);
      tile_done = 1'b0;
      chk("t4_err", err_ovr, 1);
      chk("t4_row", dif.out_row, 2);
      wait_idle();
      chk("t4_err_sticky", err_ovr, 1);

      // T5: reset at row 2
      tile_done = 1'b1;
      step(1);
      tile_done = 1'b0;
      step(2);
      rst = 1'b1;
      step(1);
      rst = 1'b0;
      chk("t5_valid", dif.out_valid, 0);
      chk("t5_data", dif.out_data, 0);
      chk("t5_row", dif.out_row, 0);
      chk("t5_busy", busy, 0);
      chk("t5_clc", clc, 0);
      chk("t5_err", err_ovr, 0);
      tile_done = 1'b1;
      step(1);
      tile_done = 1'b0;
      chk("t5_restart_row", dif.out_row, 0);
      chk("t5_restart_valid", dif.out_valid, 1);
      wait_idle();

      // Random tiles, random backpressure, occasional overrun pulses
      for (int cyc = 0; cyc < 800; cyc++) begin
         dif.out_ready = ($urandom % 4) != 0;
         if (!m_busy && ($urandom % 3) == 0) begin
            for (int r = 0; r < AH; r++)
               for (int c = 0; c < BW; c++) begin
                  lo[r][c] = $urandom; hi[r][c] = $urandom;
               end
            tile_done = 1'b1;
         end else begin
            tile_done = m_busy && ($urandom % 25) == 0;
         end
         step(1);
      end
      tile_done = 1'b0;
      dif.out_ready = 1'b1;
      wait_idle();

      // Single-row array: row 0 is also the last row
      res1 = {32'hFFFF_FFFF, 32'd7, 32'd5, 32'd10};
      td1 = 1'b1;
      step(1);
      td1 = 1'b0;
      chk("a1_valid", dif1.out_valid, 1);
      chk("a1_last", dif1.out_last, 1);
      chk("a1_data", dif1.out_data, {32'd6, 32'd15});
      step(1);
      chk("a1_hold", dif1.out_valid, 1);
      dif1.out_ready = 1'b1;
      step(1);
      chk("a1_clc", clc1, 1);
      chk("a1_valid_low", dif1.out_valid, 0);
      step(1);
      chk("a1_clc_end", clc1, 0);
      chk("a1_busy_end", busy1, 0);

      chk_en = 1'b0;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
